// File: rtl/mem_access_controller_pkg.sv
// mem_access_controller_pkg: funct3 encodings, FSM states and access-size helpers
package mem_access_controller_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } access_size_t;

  function automatic access_size_t size_of(input logic [2:0] f3);
    return access_size_t'(f3[1:0]);
  endfunction

  // Loads accept the unsigned variants; stores only B/H/W.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
    return is_load ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) : (f3 inside {F3_B, F3_H, F3_W});
  endfunction

endpackage

// File: rtl/mem_access_controller_load_formatter.sv
// mem_access_controller_load_formatter: extracts and sign/zero extends a load from the raw memory word
module mem_access_controller_load_formatter
  import mem_access_controller_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
             (i_funct3 == F3_BU) ? {24'd0, w_byte} :
             (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
             (i_funct3 == F3_HU) ? {16'd0, w_half} : i_rdata;
  end

endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: MEM-stage req/ack memory port driver with pipeline stall,
// load formatting and store lane replication.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int data_bits      = 32,
  parameter int timeout_cycles = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [2:0]           funct3_in,
  input  logic [data_bits-1:0] alu_result_in,
  input  logic [data_bits-1:0] store_data_in,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [data_bits-1:0] mem_addr,
  output logic [data_bits-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [data_bits-1:0] mem_rdata,
  output logic                 stall_out,
  output logic [data_bits-1:0] data_memory_out,
  output logic                 access_fault_out,
  output logic                 bus_error_out
);

  localparam int cnt_w = $clog2(timeout_cycles + 1);

  state_t               r_state;
  logic [cnt_w-1:0]     r_cnt;
  logic                 r_is_load;
  logic [2:0]           r_funct3;
  logic [1:0]           r_lane;
  logic                 r_req;
  logic                 r_we;
  logic [data_bits-1:0] r_addr;
  logic [data_bits-1:0] r_wdata;
  logic [data_bits-1:0] r_dout;
  logic [3:0]           r_be;
  logic                 r_bus_err;

  access_size_t         w_size;
  logic [1:0]           w_lane;
  logic                 w_access;
  logic                 w_legal;
  logic                 w_aligned;
  logic                 w_start;
  logic                 w_fault;
  logic [data_bits-1:0] w_wdata;
  logic [3:0]           w_be;
  logic [data_bits-1:0] w_ld;

  always_comb begin
    w_size    = size_of(funct3_in);
    w_lane    = alu_result_in[1:0];
    w_access  = valid_in & (mem_read_in | mem_write_in) & ~rst;
    w_legal   = f3_legal(funct3_in, mem_read_in);
    w_aligned = (w_size == SZ_WORD) ? (w_lane == 2'b00) : (w_size == SZ_HALF) ? ~w_lane[0] : 1'b1;
    w_start   = (r_state == ST_IDLE) & w_access & w_legal & w_aligned;
    w_fault   = (r_state == ST_IDLE) & w_access & ~(w_legal & w_aligned);
    w_wdata   = (w_size == SZ_BYTE) ? {4{store_data_in[7:0]}} :
                (w_size == SZ_HALF) ? {2{store_data_in[15:0]}} : store_data_in;
    w_be      = (w_size == SZ_BYTE) ? 4'b0001 << w_lane :
                (w_size == SZ_HALF) ? 4'b0011 << {w_lane[1], 1'b0} : 4'b1111;
  end

  mem_access_controller_load_formatter u_load_formatter (
    .i_funct3 (r_funct3),
    .i_lane   (r_lane),
    .i_rdata  (mem_rdata),
    .o_data   (w_ld)
  );

  // The stall covers the accept cycle and all of WAIT; DONE releases the pipeline once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_load <= 1'b0;
      r_funct3  <= '0;
      r_lane    <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_dout    <= '0;
      r_bus_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_start) begin
        r_state   <= ST_WAIT;
        r_cnt     <= '0;
        r_is_load <= mem_read_in;
        r_funct3  <= funct3_in;
        r_lane    <= w_lane;
        r_req     <= 1'b1;
        r_we      <= mem_write_in & ~mem_read_in;
        r_addr    <= {alu_result_in[data_bits-1:2], 2'b00};
        r_wdata   <= w_wdata;
        r_be      <= w_be;
      end else if (w_fault) begin
        r_dout <= '0;
      end
    end else if (r_state == ST_WAIT) begin
      if (mem_ack) begin
        r_state <= ST_DONE;
        r_req   <= 1'b0;
        if (r_is_load) r_dout <= w_ld;
      end else if (r_cnt == cnt_w'(timeout_cycles - 1)) begin
        r_state   <= ST_DONE;
        r_req     <= 1'b0;
        r_bus_err <= 1'b1;
        r_dout    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_state <= ST_IDLE;
    end
  end

  assign mem_req          = r_req;
  assign mem_we           = r_we;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_be           = r_be;
  assign data_memory_out  = r_dout;
  assign bus_error_out    = r_bus_err;
  assign stall_out        = w_start | ((r_state == ST_WAIT) & ~rst);
  assign access_fault_out = w_fault;

endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: directed stimulus, per-cycle model comparison and literal checks.
module tb_mem_access_controller;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = 3'b000;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_out;
  logic [31:0] data_memory_out;
  logic        access_fault_out;
  logic        bus_error_out;

  mem_access_controller #(.data_bits(32), .timeout_cycles(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .funct3_in        (funct3_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_be           (mem_be),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .stall_out        (stall_out),
    .data_memory_out  (data_memory_out),
    .access_fault_out (access_fault_out),
    .bus_error_out    (bus_error_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic access_ok(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = rd ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    if (!legal) return 1'b0;
    if (f3 % 4 == 1) return (addr % 2) == 0;
    if (f3 % 4 == 2) return (addr % 4) == 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 % 4 == 0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 % 4 == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input int off);
    if (f3 % 4 == 0) return 4'(1 << off);
    if (f3 % 4 == 1) return 4'(3 << (off & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (8 * (off & 2))) & 32'hFFFF;
    if (f3 == 0) return (b >= 128) ? b - 32'd256 : b;
    if (f3 == 4) return b;
    if (f3 == 1) return (h >= 32768) ? h - 32'd65536 : h;
    if (f3 == 5) return h;
    return rd;
  endfunction

  // Transaction model: phase 0 = no access, 1 = waiting for memory, 2 = release cycle.
  int          m_phase = 0;
  int          m_waited = 0;
  int          m_off = 0;
  logic        m_ready = 1'b0;
  logic        m_load = 1'b0;
  logic [2:0]  m_f3 = '0;
  logic        m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_dout = '0;
  logic [3:0]  m_be = '0;

  function automatic logic wants();
    return valid_in && (mem_read_in || mem_write_in);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      m_dout = 0; m_err = 0; m_waited = 0; m_ready = 1;
    end else if (m_phase == 0) begin
      if (wants() && access_ok(mem_read_in, funct3_in, alu_result_in)) begin
        m_phase = 1; m_waited = 0; m_req = 1; m_we = !mem_read_in;
        m_addr = alu_result_in & ~32'd3; m_off = int'(alu_result_in % 4);
        m_wdata = exp_wdata(funct3_in, store_data_in); m_be = exp_be(funct3_in, m_off);
        m_f3 = funct3_in; m_load = mem_read_in;
      end else if (wants()) m_dout = 0;
    end else if (m_phase == 1) begin
      m_waited++;
      if (mem_ack) begin
        m_phase = 2; m_req = 0;
        if (m_load) m_dout = exp_load(m_f3, m_off, mem_rdata);
      end else if (m_waited == TIMEOUT) begin
        m_phase = 2; m_req = 0; m_err = 1; m_dout = 0;
      end
    end else m_phase = 0;
  end

  always @(negedge clk) begin
    if (m_ready && !rst) begin
      logic ok;
      ok = access_ok(mem_read_in, funct3_in, alu_result_in);
      chk("stall", 32'(stall_out), 32'(m_phase == 1 || (m_phase == 0 && wants() && ok)));
      chk("fault", 32'(access_fault_out), 32'(m_phase == 0 && wants() && !ok));
      chk("dout", data_memory_out, m_dout);
      chk("req", 32'(mem_req), 32'(m_req));
      chk("bus_err", 32'(bus_error_out), 32'(m_err));
      if (m_req) begin
        chk("addr", mem_addr, m_addr);
        chk("be", 32'(mem_be), 32'(m_be));
        chk("we", 32'(mem_we), 32'(m_we));
        if (m_we) chk("wdata", mem_wdata, m_wdata);
      end
    end
  end

  int          r_stalls;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we, r_fault;

  // Issue an access at posedge+1 and return at the negedge of the first unstalled cycle.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] sd, input int ack_at, input logic [31:0] rdata);
    bit done = 0;
    valid_in = 1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
    alu_result_in = addr; store_data_in = sd; mem_rdata = rdata; mem_ack = 0;
    r_stalls = 0; r_addr = 0; r_wdata = 0; r_be = 0; r_we = 0; r_fault = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) r_fault = access_fault_out;
      if (c == 1) begin r_addr = mem_addr; r_wdata = mem_wdata; r_be = mem_be; r_we = mem_we; end
      if (!stall_out) done = 1;
      else begin
        r_stalls++;
        @(posedge clk); #1;
        mem_ack = (c == ack_at);
      end
    end
    if (!done) chk("run_budget", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; mem_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0); chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", 32'(mem_be), 0); chk("rst_dout", data_memory_out, 0);
    chk("rst_stall", 32'(stall_out), 0); chk("rst_berr", 32'(bus_error_out), 0);
    @(posedge clk); #1;

    run(1, 0, 3'b010, 32'h104, 0, 0, 32'hCAFEBABE);
    chk("lw_addr", r_addr, 32'h104); chk("lw_be", 32'(r_be), 32'hF);
    chk("lw_stalls", r_stalls, 2); chk("lw_dout", data_memory_out, 32'hCAFEBABE);
    idle_cycle();
    run(1, 0, 3'b000, 32'h103, 0, 0, 32'h80223344);
    chk("lb_dout", data_memory_out, 32'hFFFFFF80);
    idle_cycle();
    run(1, 0, 3'b100, 32'h103, 0, 1, 32'h80223344);
    chk("lbu_dout", data_memory_out, 32'h00000080);
    idle_cycle();
    run(1, 0, 3'b001, 32'h102, 0, 0, 32'h80223344);
    chk("lh_dout", data_memory_out, 32'hFFFF8022);
    idle_cycle();
    run(1, 0, 3'b101, 32'h102, 0, 0, 32'h80223344);
    chk("lhu_dout", data_memory_out, 32'h00008022);
    idle_cycle();

    run(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'hDEADDEAD);
    chk("sh_we", 32'(r_we), 1); chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_be", 32'(r_be), 32'hC); chk("sh_stalls", r_stalls, 4);
    chk("sh_dout", data_memory_out, 32'h00008022);
    idle_cycle();
    run(0, 1, 3'b000, 32'h201, 32'h0000005A, 1, 0);
    chk("sb_wdata", r_wdata, 32'h5A5A5A5A); chk("sb_be", 32'(r_be), 32'h2);
    chk("sb_stalls", r_stalls, 3);
    idle_cycle();

    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("idle_ack_dout", data_memory_out, 32'h00008022);
    idle_cycle();

    run(1, 0, 3'b010, 32'h102, 0, 0, 32'h77777777);
    chk("mis_fault", 32'(r_fault), 1); chk("mis_stalls", r_stalls, 0);
    chk("mis_req", 32'(mem_req), 0);
    idle_cycle();
    @(negedge clk);
    chk("mis_dout", data_memory_out, 0);
    @(posedge clk); #1;
    run(1, 0, 3'b011, 32'h100, 0, 0, 32'h77777777);
    chk("f3_fault", 32'(r_fault), 1); chk("f3_stalls", r_stalls, 0);
    idle_cycle();
    run(0, 1, 3'b100, 32'h100, 32'h1, 0, 0);
    chk("st_f3_fault", 32'(r_fault), 1);
    idle_cycle();

    run(1, 1, 3'b010, 32'h108, 32'h99, 0, 32'h11112222);
    chk("rw_we", 32'(r_we), 0); chk("rw_dout", data_memory_out, 32'h11112222);
    idle_cycle();

    run(1, 0, 3'b010, 32'h300, 0, -1, 32'h12345678);
    chk("to_stalls", r_stalls, 17); chk("to_berr", 32'(bus_error_out), 1);
    chk("to_req", 32'(mem_req), 0); chk("to_dout", data_memory_out, 0);
    idle_cycle();
    run(1, 0, 3'b010, 32'h304, 0, 0, 32'h0BADF00D);
    chk("after_to_dout", data_memory_out, 32'h0BADF00D);
    chk("berr_sticky", 32'(bus_error_out), 1);
    idle_cycle();

    valid_in = 1; mem_read_in = 1; funct3_in = 3'b010; alu_result_in = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; valid_in = 0; mem_read_in = 0;
    @(posedge clk); #1;
    rst = 0; mem_ack = 1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    chk("mr_req", 32'(mem_req), 0); chk("mr_addr", mem_addr, 0);
    chk("mr_be", 32'(mem_be), 0); chk("mr_dout", data_memory_out, 0);
    chk("mr_stall", 32'(stall_out), 0); chk("mr_berr", 32'(bus_error_out), 0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("mr_late_dout", data_memory_out, 0);
    @(posedge clk); #1;
    run(1, 0, 3'b100, 32'h401, 0, 0, 32'h0000A500);
    chk("post_rst_dout", data_memory_out, 32'h000000A5); chk("post_rst_stalls", r_stalls, 2);
    idle_cycle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
